// File: rtl/bz_mem_pkg.sv
// Shared memory-map constants and drain FSM state type for the vector RAM path.
// Used by the store drain and by the address decoder.
package bz_mem_pkg;

  typedef enum logic [1:0] {IDLE, POP, WRITE, VG} drain_state_t;

  localparam logic [15:0] VRAM_BASE = 16'h2000;
  localparam logic [15:0] VRAM_SIZE = 16'h2000;
  localparam int ADDR_W = $clog2(VRAM_SIZE);

  // 17-bit compare so a window ending at 16'hFFFF+1 cannot wrap
  function automatic logic in_window(input logic [15:0] addr);
    return ({1'b0, addr} >= {1'b0, VRAM_BASE}) &&
           ({1'b0, addr} < ({1'b0, VRAM_BASE} + {1'b0, VRAM_SIZE}));
  endfunction

endpackage

// File: rtl/vram_store_drain_if.sv
// Store-queue head handshake: the queue presents data/addr/empty and pops on can_write.
interface vram_store_drain_if;

  logic [7:0]  q_data;
  logic [15:0] q_addr;
  logic        q_empty;
  logic        q_can_write;

  modport master (output q_data, output q_addr, output q_empty, input q_can_write);
  modport slave  (input q_data, input q_addr, input q_empty, output q_can_write);

endinterface

// File: rtl/drain_starve_ctr.sv
// Counts consecutive VG-granted cycles with writes waiting; hit flags the cycle that
// reaches LIMIT so the drain can steal one write slot.
module drain_starve_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  assign hit = inc && (count == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vram_store_drain.sv
// Drains buffered CPU stores into the vector BRAM, sharing the port with VG reads,
// and holds back VGGO until every queued vector write has landed.
module vram_store_drain
  import bz_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  vram_store_drain_if.slave   q,
  input  logic                vg_req,
  input  logic [ADDR_W-1:0]   vg_addr,
  output logic                vg_grant,
  output logic [7:0]          vg_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [7:0]          ram_wdata,
  output logic                ram_we,
  input  logic [7:0]          ram_rdata,
  input  logic                vggo_in,
  output logic                vggo_out,
  output logic                busy,
  output logic                range_err
);

  drain_state_t        state;
  drain_state_t        state_nx;
  logic                starve_hit;
  logic                vggo_pend;
  logic                vggo_fire;
  logic                pend_nx;
  logic                in_range;
  logic [ADDR_W-1:0]   offset;

  assign q.q_can_write = (state == POP);
  assign vg_rdata      = ram_rdata;
  assign in_range      = in_window(q.q_addr);
  assign offset        = ADDR_W'(q.q_addr - VRAM_BASE);

  drain_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state != VG) || q.q_empty),
    .inc   ((state == VG) && vg_req && !q.q_empty),
    .hit   (starve_hit)
  );

  // VG wins from IDLE/WRITE; a started POP always finishes its WRITE first
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, WRITE: begin
        if (vg_req)          state_nx = VG;
        else if (!q.q_empty) state_nx = POP;
        else                 state_nx = IDLE;
      end
      POP:     state_nx = WRITE;
      VG: begin
        if (!vg_req)         state_nx = IDLE;
        else if (starve_hit) state_nx = POP;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign vggo_fire = vggo_pend && q.q_empty && ((state_nx == IDLE) || (state_nx == VG));
  assign pend_nx   = (vggo_pend && !vggo_fire) || vggo_in;

  // Outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vg_grant  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      vggo_out  <= 1'b0;
      vggo_pend <= 1'b0;
      busy      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state     <= state_nx;
      vg_grant  <= (state_nx == VG);
      ram_we    <= (state == POP) && in_range;
      vggo_out  <= vggo_fire;
      vggo_pend <= pend_nx;
      busy      <= (state_nx == POP) || (state_nx == WRITE) || !q.q_empty || pend_nx;
      if (state == POP) begin
        ram_addr  <= offset;
        ram_wdata <= q.q_data;
        range_err <= range_err | !in_range;
      end else if (state_nx == VG) begin
        ram_addr  <= vg_addr;
      end
    end
  end

endmodule

// File: tb/tb_vram_store_drain.sv
// Directed bench for vram_store_drain with a behavioural store queue and BRAM.
module tb_vram_store_drain;
  import bz_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vg_req;
  logic [ADDR_W-1:0] vg_addr;
  logic              vg_grant;
  logic [7:0]        vg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic              vggo_in;
  logic              vggo_out;
  logic              busy;
  logic              range_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  qd [0:63];
  logic [15:0] qa [0:63];
  int head = 0;
  int tail = 0;

  logic [7:0] mem [0:8191];

  logic [11:0] gpat;
  logic [11:0] cpat;
  logic [5:0]  vpat;
  logic [5:0]  bpat;

  vram_store_drain_if qif ();

  vram_store_drain #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (qif),
    .vg_req    (vg_req),
    .vg_addr   (vg_addr),
    .vg_grant  (vg_grant),
    .vg_rdata  (vg_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .vggo_in   (vggo_in),
    .vggo_out  (vggo_out),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  // Store queue model: head is consumed on every cycle canWrite is high
  assign qif.q_data  = qd[head];
  assign qif.q_addr  = qa[head];
  assign qif.q_empty = (head == tail);

  always @(posedge clk) begin
    if (qif.q_can_write && (head != tail)) head <= head + 1;
  end

  // BRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    mem[16] <= 8'h5A;
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d);
    qa[tail] = a;
    qd[tail] = d;
    tail = tail + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    vg_req  = 1'b0;
    vg_addr = '0;
    vggo_in = 1'b0;
    #2;
    check_output("rst_ram_we",    32'(ram_we),    32'h0);
    check_output("rst_vg_grant",  32'(vg_grant),  32'h0);
    check_output("rst_busy",      32'(busy),      32'h0);
    check_output("rst_range_err", 32'(range_err), 32'h0);
    check_output("rst_vggo_out",  32'(vggo_out),  32'h0);
    check_output("rst_can_write", 32'(qif.q_can_write), 32'h0);
    check_output("rst_ram_addr",  32'(ram_addr),  32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    $display("[TB] test 1: in-window drain");
    apply_stimulus(16'h2005, 8'hAA);
    apply_stimulus(16'h2006, 8'hBB);
    apply_stimulus(16'h3FFF, 8'hCC);
    step();
    check_output("t1_pop0_cw", 32'(qif.q_can_write), 32'h1);
    check_output("t1_pop0_we", 32'(ram_we), 32'h0);
    step();
    check_output("t1_wr0_cw",   32'(qif.q_can_write), 32'h0);
    check_output("t1_wr0_we",   32'(ram_we),    32'h1);
    check_output("t1_wr0_addr", 32'(ram_addr),  32'h0005);
    check_output("t1_wr0_data", 32'(ram_wdata), 32'hAA);
    step();
    check_output("t1_pop1_cw", 32'(qif.q_can_write), 32'h1);
    step();
    check_output("t1_wr1_addr", 32'(ram_addr),  32'h0006);
    check_output("t1_wr1_data", 32'(ram_wdata), 32'hBB);
    step();
    check_output("t1_pop2_cw", 32'(qif.q_can_write), 32'h1);
    step();
    check_output("t1_wr2_we",   32'(ram_we),    32'h1);
    check_output("t1_wr2_addr", 32'(ram_addr),  32'h1FFF);
    check_output("t1_wr2_data", 32'(ram_wdata), 32'hCC);
    step();
    check_output("t1_idle_we",   32'(ram_we), 32'h0);
    check_output("t1_idle_cw",   32'(qif.q_can_write), 32'h0);
    check_output("t1_idle_busy", 32'(busy), 32'h0);
    check_output("t1_mem_0005",  32'(mem[5]),    32'hAA);
    check_output("t1_mem_0006",  32'(mem[6]),    32'hBB);
    check_output("t1_mem_1fff",  32'(mem[8191]), 32'hCC);
    check_output("t1_range_err", 32'(range_err), 32'h0);

    $display("[TB] test 2: out-of-window entry");
    apply_stimulus(16'h4000, 8'h11);
    apply_stimulus(16'h2001, 8'h22);
    step();
    check_output("t2_pop0_cw", 32'(qif.q_can_write), 32'h1);
    step();
    check_output("t2_wr0_we",  32'(ram_we),    32'h0);
    check_output("t2_err_set", 32'(range_err), 32'h1);
    step();
    step();
    check_output("t2_wr1_we",   32'(ram_we),    32'h1);
    check_output("t2_wr1_addr", 32'(ram_addr),  32'h0001);
    check_output("t2_wr1_data", 32'(ram_wdata), 32'h22);
    step();
    check_output("t2_err_hold", 32'(range_err), 32'h1);
    check_output("t2_mem_0001", 32'(mem[1]), 32'h22);
    check_output("t2_mem_0000", 32'(mem[0]), 32'h00);

    $display("[TB] test 3: VG request during POP");
    vg_addr = 13'h0010;
    apply_stimulus(16'h2020, 8'h33);
    step();
    check_output("t3_pop_cw", 32'(qif.q_can_write), 32'h1);
    vg_req = 1'b1;
    step();
    check_output("t3_wr_we",    32'(ram_we),   32'h1);
    check_output("t3_wr_grant", 32'(vg_grant), 32'h0);
    step();
    check_output("t3_vg_grant", 32'(vg_grant), 32'h1);
    check_output("t3_vg_addr",  32'(ram_addr), 32'h0010);
    check_output("t3_vg_we",    32'(ram_we),   32'h0);
    step();
    check_output("t3_vg_rdata", 32'(vg_rdata), 32'h5A);
    vg_req = 1'b0;
    step();
    check_output("t3_release",  32'(vg_grant), 32'h0);
    check_output("t3_mem_0020", 32'(mem[32]), 32'h33);

    $display("[TB] test 4: starvation slot");
    vg_req = 1'b1;
    step();
    check_output("t4_grant_start", 32'(vg_grant), 32'h1);
    apply_stimulus(16'h2030, 8'h44);
    apply_stimulus(16'h2031, 8'h55);
    for (int k = 0; k < 12; k++) begin
      step();
      gpat[k] = vg_grant;
      cpat[k] = qif.q_can_write;
    end
    check_output("t4_grant_pat", 32'(gpat), 32'h9E7);
    check_output("t4_cw_pat",    32'(cpat), 32'h208);
    check_output("t4_mem_0030",  32'(mem[48]), 32'h44);
    check_output("t4_mem_0031",  32'(mem[49]), 32'h55);
    vg_req = 1'b0;
    step();
    check_output("t4_release", 32'(vg_grant), 32'h0);

    $display("[TB] test 5: VGGO gating");
    apply_stimulus(16'h2040, 8'h66);
    apply_stimulus(16'h2041, 8'h77);
    vggo_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      vggo_in = (k == 0);
      vpat[k] = vggo_out;
      bpat[k] = busy;
    end
    check_output("t5_vggo_pat", 32'(vpat), 32'h10);
    check_output("t5_busy_pat", 32'(bpat), 32'h0F);
    check_output("t5_mem_0041", 32'(mem[65]), 32'h77);

    $display("[TB] test 6: async reset during WRITE");
    apply_stimulus(16'h2050, 8'h88);
    apply_stimulus(16'h2051, 8'h99);
    apply_stimulus(16'h2052, 8'hA5);
    step();
    step();
    check_output("t6_wr_we", 32'(ram_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_we",    32'(ram_we),    32'h0);
    check_output("t6_rst_addr",  32'(ram_addr),  32'h0);
    check_output("t6_rst_wdata", 32'(ram_wdata), 32'h0);
    check_output("t6_rst_busy",  32'(busy),      32'h0);
    check_output("t6_rst_cw",    32'(qif.q_can_write), 32'h0);
    step();
    rst_n = 1'b1;
    check_output("t6_rel_cw", 32'(qif.q_can_write), 32'h0);
    step();
    check_output("t6_pop_cw", 32'(qif.q_can_write), 32'h1);
    step();
    check_output("t6_wr_addr", 32'(ram_addr),  32'h0051);
    check_output("t6_wr_data", 32'(ram_wdata), 32'h99);
    step();
    step();
    check_output("t6_wr2_addr", 32'(ram_addr), 32'h0052);
    step();
    check_output("t6_mem_0050", 32'(mem[80]), 32'h00);
    check_output("t6_mem_0051", 32'(mem[81]), 32'h99);
    check_output("t6_mem_0052", 32'(mem[82]), 32'hA5);
    check_output("t6_busy",     32'(busy),      32'h0);
    check_output("t6_range_err", 32'(range_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
